pipe_hazard_ctrl: RTL and testbench

//  Parametrised pipeline controller for the RV32I in-order core: owns the PC register, per-stage valid bits,

---
 rtl/pipe_ctrl_pkg.sv | 22 ++
 rtl/pipe_fwd_sel.sv | 41 ++++
 rtl/pipe_hazard_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// | Module      : pipe_ctrl_pkg                                              |
// | Description : Shared encodings for the RV32I pipeline controller:        |
// |               forwarding-select codes and controller FSM states.         |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
package pipe_ctrl_pkg;

  // EX operand source selects
  typedef logic [1:0] fwd_sel_t;
  localparam fwd_sel_t FWD_RF  = 2'b00;  // register file read data
  localparam fwd_sel_t FWD_WB  = 2'b01;  // WB-stage write data
  localparam fwd_sel_t FWD_MEM = 2'b10;  // MEM-stage ALU result

  // Controller FSM state encoding
  localparam logic [1:0] RUN      = 2'b00;
  localparam logic [1:0] LU_STALL = 2'b01;
  localparam logic [1:0] MEM_WAIT = 2'b10;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_fwd_sel.sv
`default_nettype none
// ============================================================================
// | Module      : pipe_fwd_sel                                               |
// | Description : Forwarding select for a single EX source operand. The      |
// |               youngest producer (MEM) wins over WB; x0 never forwards.   |
// | Ports       : ex_rs        - EX source register index                    |
// |               mem_rd/_we   - MEM destination and its write enable        |
// |               wb_rd/_we    - WB destination and its write enable         |
// |               fwd_sel      - 00 regfile, 01 WB data, 10 MEM result       |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
module pipe_fwd_sel
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  output fwd_sel_t          fwd_sel
);

  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs);
  assign w_wb_hit  = wb_regwrite  && (wb_rd  != '0) && (wb_rd  == ex_rs);

  always_comb begin
    fwd_sel = FWD_RF;
    if (w_mem_hit) begin
      fwd_sel = FWD_MEM;
    end else if (w_wb_hit) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule : pipe_fwd_sel
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// | Module      : pipe_hazard_ctrl                                           |
// | Description : In-order pipeline controller. Owns the PC and per-stage    |
// |               valid bits; handles load-use stall, taken-branch redirect, |
// |               data-memory wait freeze and EX forwarding selects.         |
// | Ports       : clk, rst (sync, active-high)                               |
// |               id_*  - ID source regs / use flags                         |
// |               ex_*  - EX sources, dest, memread, regwrite                |
// |               mem_*/wb_* - later-stage dest and regwrite                 |
// |               br_taken/br_target - branch resolved in BR_STAGE           |
// |               mem_busy - data memory not ready                           |
// |               pc_out, stage_valid, hold_front, hold_all, fwd_a, fwd_b    |
// | Option      : PIPE_PERF_CNT_EN adds perf_cycles/stalls/flushes/retired   |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NSTAGE   = 5,
  parameter int              BR_STAGE = 3,
  parameter int              REG_AW   = 5,
  parameter int              PC_INC   = 1,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use1,
  input  logic              id_use2,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_memread,
  input  logic              ex_regwrite,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  input  logic              br_taken,
  input  logic [XLEN-1:0]   br_target,
  input  logic              mem_busy,
  output logic [XLEN-1:0]   pc_out,
  output logic [NSTAGE-1:0] stage_valid,
  output logic              hold_front,
  output logic              hold_all,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_stalls,
  output logic [31:0]       perf_flushes,
  output logic [31:0]       perf_retired
`endif
);

  logic [XLEN-1:0]   pc_q, pc_d;
  logic [NSTAGE-1:0] valid_q, valid_d;
  logic [1:0]        state_q, state_d;

  logic      w_lu_hz;
  logic      w_redirect;
  logic      w_lu_stall;
  fwd_sel_t  w_fwd_a;
  fwd_sel_t  w_fwd_b;

  // Load in EX whose result the ID instruction needs. Suppressed while in
  // LU_STALL so a single producer/consumer pair never stalls twice.
  assign w_lu_hz = ex_memread && ex_regwrite && valid_q[2] && (ex_rd != '0) &&
                   ((id_use1 && (id_rs1 == ex_rd)) || (id_use2 && (id_rs2 == ex_rd))) &&
                   (state_q != LU_STALL);

  // Priority: mem_busy > redirect > load-use. A redirect squashes the
  // stalled instruction, so the coincident load-use is dropped.
  assign w_redirect = !mem_busy && br_taken && valid_q[BR_STAGE];
  assign w_lu_stall = !mem_busy && !w_redirect && w_lu_hz;

  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;
    state_d = state_q;
    if (mem_busy) begin
      state_d = MEM_WAIT;
    end else if (w_redirect) begin
      pc_d       = br_target;
      valid_d[0] = 1'b1;
      for (int i = 1; i < NSTAGE; i++) begin
        valid_d[i] = (i <= BR_STAGE) ? 1'b0 : valid_q[i-1];
      end
      state_d = RUN;
    end else if (w_lu_stall) begin
      // IF and ID hold, EX receives a bubble, the rest drains
      valid_d[2] = 1'b0;
      for (int i = 3; i < NSTAGE; i++) begin
        valid_d[i] = valid_q[i-1];
      end
      state_d = LU_STALL;
    end else begin
      pc_d       = pc_q + XLEN'(PC_INC);
      valid_d[0] = 1'b1;
      for (int i = 1; i < NSTAGE; i++) begin
        valid_d[i] = valid_q[i-1];
      end
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      valid_q <= '0;
      state_q <= RUN;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      state_q <= state_d;
    end
  end

  pipe_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .ex_rs        (ex_rs1),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .fwd_sel      (w_fwd_a)
  );

  pipe_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .ex_rs        (ex_rs2),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .fwd_sel      (w_fwd_b)
  );

  // Controls are forced idle while reset is asserted.
  assign pc_out      = pc_q;
  assign stage_valid = valid_q;
  assign hold_all    = !rst && mem_busy;
  assign hold_front  = !rst && w_lu_stall;
  assign fwd_a       = rst ? FWD_RF : w_fwd_a;
  assign fwd_b       = rst ? FWD_RF : w_fwd_b;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] stl_q, stl_d;
  logic [31:0] fls_q, fls_d;
  logic [31:0] ret_q, ret_d;

  always_comb begin
    cyc_d = cyc_q + 32'd1;
    stl_d = stl_q + {31'd0, (hold_front || hold_all)};
    fls_d = fls_q + {31'd0, w_redirect};
    ret_d = ret_q + {31'd0, (valid_q[NSTAGE-1] && !hold_all)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
      stl_q <= '0;
      fls_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      stl_q <= stl_d;
      fls_q <= fls_d;
      ret_q <= ret_d;
    end
  end

  assign perf_cycles  = cyc_q;
  assign perf_stalls  = stl_q;
  assign perf_flushes = fls_q;
  assign perf_retired = ret_q;
`endif

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// | Module      : tb_pipe_hazard_ctrl                                        |
// | Description : Directed self-checking bench for pipe_hazard_ctrl with    |
// |               hand-computed expected values.                             |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic        id_use1, id_use2, ex_memread, ex_regwrite;
  logic        mem_regwrite, wb_regwrite, br_taken, mem_busy;
  logic [31:0] br_target;
  logic [31:0] pc_out;
  logic [4:0]  stage_valid;
  logic        hold_front, hold_all;
  logic [1:0]  fwd_a, fwd_b;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_cycles, perf_stalls, perf_flushes, perf_retired;
`endif

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use1      (id_use1),
    .id_use2      (id_use2),
    .ex_rs1       (ex_rs1),
    .ex_rs2       (ex_rs2),
    .ex_rd        (ex_rd),
    .ex_memread   (ex_memread),
    .ex_regwrite  (ex_regwrite),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .mem_busy     (mem_busy),
    .pc_out       (pc_out),
    .stage_valid  (stage_valid),
    .hold_front   (hold_front),
    .hold_all     (hold_all),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b)
`ifdef PIPE_PERF_CNT_EN
    ,
    .perf_cycles  (perf_cycles),
    .perf_stalls  (perf_stalls),
    .perf_flushes (perf_flushes),
    .perf_retired (perf_retired)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [31:0] pc, input logic [4:0] v);
    check({tag, "_pc"}, pc_out, pc);
    check({tag, "_valid"}, {27'd0, stage_valid}, {27'd0, v});
  endtask

  initial begin
    rst = 1'b1;
    id_rs1 = '0; id_rs2 = '0; id_use1 = 1'b0; id_use2 = 1'b0;
    ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_memread = 1'b0; ex_regwrite = 1'b0;
    mem_rd = '0; mem_regwrite = 1'b0; wb_rd = '0; wb_regwrite = 1'b0;
    br_taken = 1'b0; br_target = '0; mem_busy = 1'b0;

    // Reset with noisy inputs: controls must stay idle
    mem_busy = 1'b1; mem_regwrite = 1'b1; mem_rd = 5'd7; ex_rs1 = 5'd7;
    tick(); tick(); tick();
    check_state("reset", 32'd0, 5'b00000);
    check("reset_hold_all", {31'd0, hold_all}, 32'd0);
    check("reset_hold_front", {31'd0, hold_front}, 32'd0);
    check("reset_fwd_a", {30'd0, fwd_a}, 32'd0);

    // Release and fill the pipe
    rst = 1'b0; mem_busy = 1'b0; mem_regwrite = 1'b0; mem_rd = '0; ex_rs1 = '0;
    tick(); check_state("fill1", 32'd1, 5'b00001);
    tick(); check_state("fill2", 32'd2, 5'b00011);
    tick(); check_state("fill3", 32'd3, 5'b00111);
    tick(); check_state("fill4", 32'd4, 5'b01111);
    tick(); check_state("fill5", 32'd5, 5'b11111);

    // Load-use: lw x5 in EX, add x6,x5,x1 in ID
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use1 = 1'b1;
    #1 check("lu_hold_front", {31'd0, hold_front}, 32'd1);
    check("lu_hold_all", {31'd0, hold_all}, 32'd0);
    tick(); check_state("lu_bubble", 32'd5, 5'b11011);
    check("lu_no_second", {31'd0, hold_front}, 32'd0);
    // load moves to MEM, add still in ID
    ex_memread = 1'b0; ex_regwrite = 1'b0; ex_rd = '0; id_rs1 = '0; id_use1 = 1'b0;
    mem_rd = 5'd5; mem_regwrite = 1'b1;
    tick(); check_state("lu_resume", 32'd6, 5'b10111);
    // load in WB, add in EX reading x5
    mem_rd = '0; mem_regwrite = 1'b0; wb_rd = 5'd5; wb_regwrite = 1'b1; ex_rs1 = 5'd5;
    #1 check("lu_fwd_a_wb", {30'd0, fwd_a}, 32'h1);
    check("lu_fwd_b_rf", {30'd0, fwd_b}, 32'h0);

    // Forwarding priority and x0
    mem_rd = 5'd7; wb_rd = 5'd7; ex_rs1 = 5'd7; ex_rs2 = 5'd7; mem_regwrite = 1'b1; wb_regwrite = 1'b1;
    #1 check("fwd_a_mem_beats_wb", {30'd0, fwd_a}, 32'h2);
    check("fwd_b_mem_beats_wb", {30'd0, fwd_b}, 32'h2);
    ex_rs2 = 5'd9; wb_rd = 5'd9;
    #1 check("fwd_b_wb_only", {30'd0, fwd_b}, 32'h1);
    mem_rd = 5'd0; wb_rd = 5'd0; ex_rs1 = 5'd0; ex_rs2 = 5'd0;
    #1 check("fwd_a_x0", {30'd0, fwd_a}, 32'h0);
    mem_regwrite = 1'b0; wb_regwrite = 1'b0;
    tick(); check_state("refill1", 32'd7, 5'b01111);
    tick(); check_state("refill2", 32'd8, 5'b11111);

    // Taken branch in stage 3
    br_taken = 1'b1; br_target = 32'h40;
    tick(); check_state("br_redirect", 32'h40, 5'b10001);
    br_taken = 1'b0;
    tick(); check_state("br_gap1", 32'h41, 5'b00011);
    tick(); check_state("br_gap2", 32'h42, 5'b00111);
    tick(); check_state("br_gap3", 32'h43, 5'b01111);
    tick(); check_state("br_full", 32'h44, 5'b11111);

    // Branch beats coincident load-use
    br_taken = 1'b1; br_target = 32'h80;
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd3; id_rs2 = 5'd3; id_use2 = 1'b1;
    #1 check("br_over_lu_hold", {31'd0, hold_front}, 32'd0);
    tick(); check_state("br_over_lu", 32'h80, 5'b10001);
    ex_memread = 1'b0; ex_regwrite = 1'b0; ex_rd = '0; id_rs2 = '0; id_use2 = 1'b0;
    // branch flag with stage 3 empty is ignored
    tick(); check_state("br_invalid_stage", 32'h81, 5'b00011);
    br_taken = 1'b0;

    // Data memory wait for 4 cycles
    mem_busy = 1'b1;
    #1 check("mw_hold_all", {31'd0, hold_all}, 32'd1);
    tick(); check_state("mw1", 32'h81, 5'b00011);
    tick(); check_state("mw2", 32'h81, 5'b00011);
    tick(); check_state("mw3", 32'h81, 5'b00011);
    tick(); check_state("mw4", 32'h81, 5'b00011);
    mem_busy = 1'b0;
    #1 check("mw_release", {31'd0, hold_all}, 32'd0);
    tick(); check_state("mw_resume", 32'h82, 5'b00111);

    // Reset during MEM_WAIT with a branch pending
    mem_busy = 1'b1;
    tick(); check_state("mw_again", 32'h82, 5'b00111);
    rst = 1'b1; br_taken = 1'b1; br_target = 32'h99;
    tick(); check_state("rst_mid", 32'd0, 5'b00000);
    check("rst_mid_hold_all", {31'd0, hold_all}, 32'd0);
    rst = 1'b0; mem_busy = 1'b0; br_taken = 1'b0;
    tick(); check_state("post_rst1", 32'd1, 5'b00001);
    tick(); tick(); tick();
    check_state("post_rst4", 32'd4, 5'b01111);

    // PC wrap after redirect to the top address
    br_taken = 1'b1; br_target = 32'hFFFF_FFFF;
    tick(); check_state("wrap_redirect", 32'hFFFF_FFFF, 5'b10001);
    br_taken = 1'b0;
    tick(); check_state("wrap", 32'd0, 5'b00011);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire
